// File: rtl/ptw_pkg.sv
// Shared types and constants for the page-table walker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ptw_pkg;

  // Walker states: IDLE -> REQ -> WAIT -> (REQ | RESP) -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } ptw_state_e;

  // Which TLB port owns the walk in flight
  typedef enum logic {
    REQ_IMEM = 1'b0,
    REQ_DMEM = 1'b1
  } ptw_req_id_e;

  // PTE layout: [63:32]=ppn, [1]=leaf, [0]=valid
  localparam int PTE_V       = 0;
  localparam int PTE_LEAF    = 1;
  localparam int PTE_PPN_LSB = 32;

endpackage

// File: rtl/ptw_rr_arb2.sv
// Two-way round-robin arbiter between the imem (bit 0) and dmem (bit 1) walk ports.
// Latency: combinational grant, same cycle as the request.
// Backpressure: grants nothing while advance is low; the caller holds its valid.
//
// Ports:
//   req_vld  in   2  request valids, bit 0 = imem, bit 1 = dmem
//   rr_last  in   1  port served by the most recent walk
//   advance  in   1  arbiter may grant this cycle
//   grant    out  2  one-hot grant (all zero when nothing is granted)
module ptw_rr_arb2
  import ptw_pkg::*;
(
  input  logic        [1:0] req_vld,
  input  ptw_req_id_e       rr_last,
  input  logic              advance,
  output logic        [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (advance) begin
      if (req_vld == 2'b11) begin
        // Tie: the port that was not served last goes first
        grant = (rr_last == REQ_DMEM) ? 2'b01 : 2'b10;
      end else begin
        grant = req_vld;
      end
    end
  end

endmodule

// File: rtl/ptw_responder.sv
// Page-table walker serving the imem and dmem TLB PTW ports; one walk in flight.
// Latency: grant -> resp_valid = 2*LEVELS+1 cycles for a full walk with zero-wait memory.
// Backpressure: req_ready only in IDLE; mem_req held until mem_req_ready; resp has none.
//
// Ports:
//   clk, reset_n                 clock and async active-low reset
//   ptbr_ppn                     root table PPN, sampled at grant
//   {imem,dmem}_ptw_req_*        walk request (valid/ready/vpn)
//   {imem,dmem}_ptw_resp_*       one-cycle response pulse with error and ppn
//   mem_req_{valid,ready,addr}   PTE read request (8-byte PTE byte address)
//   mem_resp_{valid,data}        in-order PTE read data
module ptw_responder
  import ptw_pkg::*;
#(
  parameter  int LEVELS  = 2,
  parameter  int IDX_W   = 10,
  parameter  int PPN_W   = 32,
  parameter  int PGOFF_W = 12,
  localparam int ADDR_W  = PPN_W + PGOFF_W,
  localparam int VPN_W   = LEVELS * IDX_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PPN_W-1:0]  ptbr_ppn,

  input  logic              imem_ptw_req_valid,
  output logic              imem_ptw_req_ready,
  input  logic [VPN_W-1:0]  imem_ptw_req_bits_vpn,
  input  logic              dmem_ptw_req_valid,
  output logic              dmem_ptw_req_ready,
  input  logic [VPN_W-1:0]  dmem_ptw_req_bits_vpn,

  output logic              imem_ptw_resp_valid,
  output logic              imem_ptw_resp_bits_error,
  output logic [PPN_W-1:0]  imem_ptw_resp_bits_ppn,
  output logic              dmem_ptw_resp_valid,
  output logic              dmem_ptw_resp_bits_error,
  output logic [PPN_W-1:0]  dmem_ptw_resp_bits_ppn,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_data
);

  localparam int LVL_W = $clog2(LEVELS) + 1;
  localparam int EXT_W = (VPN_W > PPN_W) ? VPN_W : PPN_W;

  ptw_state_e         state_q,   state_d;
  ptw_req_id_e        req_id_q,  req_id_d;
  ptw_req_id_e        rr_last_q, rr_last_d;
  logic [VPN_W-1:0]   vpn_q,     vpn_d;
  logic [PPN_W-1:0]   cur_ppn_q, cur_ppn_d;
  logic [LVL_W-1:0]   level_q,   level_d;
  logic               resp_err_q, resp_err_d;
  logic [PPN_W-1:0]   resp_ppn_q, resp_ppn_d;

  logic [1:0]         grant;
  int                 lvl_bits;
  logic [IDX_W-1:0]   pte_idx;
  logic               pte_v;
  logic               pte_leaf;
  logic [PPN_W-1:0]   pte_ppn;
  logic [EXT_W-1:0]   vpn_ext;
  logic [PPN_W-1:0]   leaf_ppn;
  logic               unused_pte_bits;

  ptw_rr_arb2 u_arb (
    .req_vld ({dmem_ptw_req_valid, imem_ptw_req_valid}),
    .rr_last (rr_last_q),
    .advance (state_q == ST_IDLE),
    .grant   (grant)
  );

  // Number of VPN bits below the current level's index field
  always_comb begin
    lvl_bits = int'(level_q) * IDX_W;
  end

  assign pte_idx      = IDX_W'(vpn_q >> lvl_bits);
  assign mem_req_addr = {cur_ppn_q, {PGOFF_W{1'b0}}} + (ADDR_W'(pte_idx) << 3);

  assign pte_v           = mem_resp_data[PTE_V];
  assign pte_leaf        = mem_resp_data[PTE_LEAF];
  assign pte_ppn         = PPN_W'(mem_resp_data[63:PTE_PPN_LSB]);
  assign unused_pte_bits = ^mem_resp_data[PTE_PPN_LSB-1:PTE_LEAF+1];

  // Superpage: a leaf found above level 0 maps the untranslated low VPN
  // bits straight through into the result PPN.
  always_comb begin
    vpn_ext  = EXT_W'(vpn_q);
    leaf_ppn = pte_ppn;
    for (int i = 0; i < PPN_W; i++) begin
      if (i < lvl_bits) leaf_ppn[i] = vpn_ext[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    req_id_d   = req_id_q;
    rr_last_d  = rr_last_q;
    vpn_d      = vpn_q;
    cur_ppn_d  = cur_ppn_q;
    level_d    = level_q;
    resp_err_d = resp_err_q;
    resp_ppn_d = resp_ppn_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant[1]) begin
          req_id_d = REQ_DMEM;
          vpn_d    = dmem_ptw_req_bits_vpn;
        end else if (grant[0]) begin
          req_id_d = REQ_IMEM;
          vpn_d    = imem_ptw_req_bits_vpn;
        end
        if (|grant) begin
          cur_ppn_d = ptbr_ppn;
          level_d   = LVL_W'(LEVELS - 1);
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (mem_resp_valid) begin
          if (!pte_v) begin
            resp_err_d = 1'b1;
            resp_ppn_d = '0;
            state_d    = ST_RESP;
          end else if (pte_leaf) begin
            resp_err_d = 1'b0;
            resp_ppn_d = leaf_ppn;
            state_d    = ST_RESP;
          end else if (level_q == '0) begin
            // Pointer PTE with no level left to descend into
            resp_err_d = 1'b1;
            resp_ppn_d = '0;
            state_d    = ST_RESP;
          end else begin
            cur_ppn_d = pte_ppn;
            level_d   = level_q - 1'b1;
            state_d   = ST_REQ;
          end
        end
      end

      ST_RESP: begin
        rr_last_d = req_id_q;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_id_q   <= REQ_IMEM;
      rr_last_q  <= REQ_DMEM;
      vpn_q      <= '0;
      cur_ppn_q  <= '0;
      level_q    <= '0;
      resp_err_q <= 1'b0;
      resp_ppn_q <= '0;
    end else begin
      state_q    <= state_d;
      req_id_q   <= req_id_d;
      rr_last_q  <= rr_last_d;
      vpn_q      <= vpn_d;
      cur_ppn_q  <= cur_ppn_d;
      level_q    <= level_d;
      resp_err_q <= resp_err_d;
      resp_ppn_q <= resp_ppn_d;
    end
  end

  assign imem_ptw_req_ready = grant[0];
  assign dmem_ptw_req_ready = grant[1];
  assign mem_req_valid      = (state_q == ST_REQ);

  assign imem_ptw_resp_valid      = (state_q == ST_RESP) && (req_id_q == REQ_IMEM);
  assign dmem_ptw_resp_valid      = (state_q == ST_RESP) && (req_id_q == REQ_DMEM);
  assign imem_ptw_resp_bits_error = resp_err_q;
  assign dmem_ptw_resp_bits_error = resp_err_q;
  assign imem_ptw_resp_bits_ppn   = resp_ppn_q;
  assign dmem_ptw_resp_bits_ppn   = resp_ppn_q;

endmodule

// File: tb/tb_ptw_responder.sv
// Directed bench for ptw_responder: vector table of single walks plus
// hand-written arbitration and reset-during-walk sequences.
module tb_ptw_responder;

  localparam int LEVELS = 2;
  localparam int IDX_W  = 10;
  localparam int PPN_W  = 32;
  localparam int VPN_W  = 20;
  localparam int ADDR_W = 44;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [PPN_W-1:0]  ptbr_ppn;
  logic              imem_ptw_req_valid, imem_ptw_req_ready;
  logic [VPN_W-1:0]  imem_ptw_req_bits_vpn;
  logic              dmem_ptw_req_valid, dmem_ptw_req_ready;
  logic [VPN_W-1:0]  dmem_ptw_req_bits_vpn;
  logic              imem_ptw_resp_valid, imem_ptw_resp_bits_error;
  logic [PPN_W-1:0]  imem_ptw_resp_bits_ppn;
  logic              dmem_ptw_resp_valid, dmem_ptw_resp_bits_error;
  logic [PPN_W-1:0]  dmem_ptw_resp_bits_ppn;
  logic              mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_data;

  ptw_responder #(.LEVELS(LEVELS), .IDX_W(IDX_W), .PPN_W(PPN_W), .PGOFF_W(12)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .ptbr_ppn                 (ptbr_ppn),
    .imem_ptw_req_valid       (imem_ptw_req_valid),
    .imem_ptw_req_ready       (imem_ptw_req_ready),
    .imem_ptw_req_bits_vpn    (imem_ptw_req_bits_vpn),
    .dmem_ptw_req_valid       (dmem_ptw_req_valid),
    .dmem_ptw_req_ready       (dmem_ptw_req_ready),
    .dmem_ptw_req_bits_vpn    (dmem_ptw_req_bits_vpn),
    .imem_ptw_resp_valid      (imem_ptw_resp_valid),
    .imem_ptw_resp_bits_error (imem_ptw_resp_bits_error),
    .imem_ptw_resp_bits_ppn   (imem_ptw_resp_bits_ppn),
    .dmem_ptw_resp_valid      (dmem_ptw_resp_valid),
    .dmem_ptw_resp_bits_error (dmem_ptw_resp_bits_error),
    .dmem_ptw_resp_bits_ppn   (dmem_ptw_resp_bits_ppn),
    .mem_req_valid            (mem_req_valid),
    .mem_req_ready            (mem_req_ready),
    .mem_req_addr             (mem_req_addr),
    .mem_resp_valid           (mem_resp_valid),
    .mem_resp_data            (mem_resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  // Configuration written only by the main sequence; bumping epoch reloads it.
  logic [63:0] pte_tbl [4];
  int          stall_cfg = 0;
  int          epoch     = 0;
  logic        hold_resp = 1'b0;

  // State owned only by the memory process
  int          seen_epoch = 0;
  int          rd_idx     = 0;
  int          n_reads    = 0;
  int          stall_left = 0;
  logic        hs_next    = 1'b0;
  logic        stall_seen = 1'b0;
  logic        stall_bad  = 1'b0;
  logic [ADDR_W-1:0] stall_addr;
  logic [ADDR_W-1:0] addr_arr [4];

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        rd_idx     = 0;
        n_reads    = 0;
        stall_left = stall_cfg;
        stall_seen = 1'b0;
        stall_bad  = 1'b0;
      end
      mem_resp_valid = 1'b0;
      if (hs_next && !hold_resp) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = (rd_idx < 4) ? pte_tbl[rd_idx] : 64'h0;
        rd_idx++;
        hs_next = 1'b0;
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        if (stall_left > 0) begin
          if (!stall_seen) begin
            stall_addr = mem_req_addr;
            stall_seen = 1'b1;
          end else if (mem_req_addr !== stall_addr) begin
            stall_bad = 1'b1;
          end
          stall_left--;
        end else begin
          if (stall_seen && mem_req_addr !== stall_addr) stall_bad = 1'b1;
          stall_seen    = 1'b0;
          mem_req_ready = 1'b1;
          hs_next       = 1'b1;
          if (n_reads < 4) addr_arr[n_reads] = mem_req_addr;
          n_reads++;
        end
      end
    end
  end

  task automatic set_mem(input logic [63:0] p0, input logic [63:0] p1,
                         input logic [63:0] p2, input int stall);
    pte_tbl[0] = p0;
    pte_tbl[1] = p1;
    pte_tbl[2] = p2;
    pte_tbl[3] = 64'h0;
    stall_cfg  = stall;
    epoch++;
  endtask

  // ---------------- single-walk vectors ----------------
  typedef struct {
    logic              port;    // 0 = imem, 1 = dmem
    logic [VPN_W-1:0]  vpn;
    logic [PPN_W-1:0]  ptbr;
    logic [63:0]       pte0;
    logic [63:0]       pte1;
    int                stall;
    int                nreads;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic              err;
    logic [PPN_W-1:0]  ppn;
    int                lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int   t0;
    int   guard;
    logic wrong;
    logic got;
    set_mem(v.pte0, v.pte1, 64'h0, v.stall);
    ptbr_ppn = v.ptbr;
    @(negedge clk);
    if (v.port) begin
      dmem_ptw_req_valid = 1'b1; dmem_ptw_req_bits_vpn = v.vpn;
    end else begin
      imem_ptw_req_valid = 1'b1; imem_ptw_req_bits_vpn = v.vpn;
    end
    #1;
    guard = 0;
    while (!(v.port ? dmem_ptw_req_ready : imem_ptw_req_ready) && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    chk({nm, "_grant"}, v.port ? dmem_ptw_req_ready : imem_ptw_req_ready, 1);
    t0 = cyc;
    @(negedge clk);
    imem_ptw_req_valid = 1'b0;
    dmem_ptw_req_valid = 1'b0;
    ptbr_ppn = ~v.ptbr;  // root must have been latched at grant
    #1;
    guard = 0;
    wrong = 1'b0;
    while (!(v.port ? dmem_ptw_resp_valid : imem_ptw_resp_valid) && guard < 60) begin
      if (imem_ptw_resp_valid || dmem_ptw_resp_valid) wrong = 1'b1;
      @(negedge clk); #1; guard++;
    end
    got = v.port ? dmem_ptw_resp_valid : imem_ptw_resp_valid;
    chk({nm, "_resp_seen"}, got, 1);
    chk({nm, "_other_quiet"}, {wrong, v.port ? imem_ptw_resp_valid : dmem_ptw_resp_valid}, 0);
    chk({nm, "_err"}, v.port ? dmem_ptw_resp_bits_error : imem_ptw_resp_bits_error, v.err);
    chk({nm, "_ppn"}, v.port ? dmem_ptw_resp_bits_ppn : imem_ptw_resp_bits_ppn, v.ppn);
    chk({nm, "_latency"}, 64'(cyc - t0), 64'(v.lat));
    chk({nm, "_nreads"}, 64'(n_reads), 64'(v.nreads));
    chk({nm, "_addr0"}, addr_arr[0], v.a0);
    if (v.nreads > 1) chk({nm, "_addr1"}, addr_arr[1], v.a1);
    if (v.stall > 0) chk({nm, "_addr_stable"}, stall_bad, 0);
    @(negedge clk); #1;
    chk({nm, "_pulse_end"}, {imem_ptw_resp_valid, dmem_ptw_resp_valid, mem_req_valid}, 0);
  endtask

  vec_t vecs [8];

  initial begin
    int   guard;
    int   t0;
    logic wrong;
    logic exp_dm   [3] = '{1'b0, 1'b1, 1'b0};
    logic [PPN_W-1:0]  arb_ppn  [3] = '{32'h00111000, 32'h00222000, 32'h00333000};
    logic [ADDR_W-1:0] arb_addr [3] = '{44'h5008, 44'h5010, 44'h5008};

    //        port  vpn        ptbr        pte0                    pte1                  stall nrd a0          a1         err ppn          lat
    vecs[0] = '{1'b0, 20'h00401, 32'h10,  64'h00000020_00000001, 64'h000ABCDE_00000003, 0, 2, 44'h10008,  44'h20008,  1'b0, 32'h000ABCDE, 5};
    vecs[1] = '{1'b1, 20'h12345, 32'h55,  64'h00000077_00000002, 64'h0,                 0, 1, 44'h55240,  44'h0,      1'b1, 32'h0,        3};
    vecs[2] = '{1'b0, 20'h00C05, 32'h1,   64'h00012C00_00000003, 64'h0,                 0, 1, 44'h1018,   44'h0,      1'b0, 32'h00012C05, 3};
    vecs[3] = '{1'b1, 20'hFFFFF, 32'hABC, 64'h00000300_00000001, 64'h00000999_00000001, 0, 2, 44'hABDFF8, 44'h301FF8, 1'b1, 32'h0,        5};
    vecs[4] = '{1'b0, 20'h00401, 32'h10,  64'h00000020_00000001, 64'h000ABCDE_00000003, 5, 2, 44'h10008,  44'h20008,  1'b0, 32'h000ABCDE, 10};
    vecs[5] = '{1'b1, 20'h00800, 32'h2,   64'h00000040_00000001, 64'hDEADBEEF_00000002, 0, 2, 44'h2010,   44'h40000,  1'b1, 32'h0,        5};
    vecs[6] = '{1'b0, 20'hFFFFF, 32'h0,   64'hFFFFF000_0000F0F3, 64'h0,                 0, 1, 44'h1FF8,   44'h0,      1'b0, 32'hFFFFF3FF, 3};
    vecs[7] = '{1'b1, 20'h00C05, 32'h1,   64'h00012C00_00000003, 64'h0,                 0, 1, 44'h1018,   44'h0,      1'b0, 32'h00012C05, 3};

    reset_n = 1'b0;
    ptbr_ppn = '0;
    imem_ptw_req_valid = 1'b0; imem_ptw_req_bits_vpn = '0;
    dmem_ptw_req_valid = 1'b0; dmem_ptw_req_bits_vpn = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {imem_ptw_req_ready, dmem_ptw_req_ready}, 0);
    chk("rst_mem_req", mem_req_valid, 0);
    chk("rst_resp_valid", {imem_ptw_resp_valid, dmem_ptw_resp_valid}, 0);
    chk("rst_err", {imem_ptw_resp_bits_error, dmem_ptw_resp_bits_error}, 0);
    chk("rst_imem_ppn", imem_ptw_resp_bits_ppn, 0);
    chk("rst_dmem_ppn", dmem_ptw_resp_bits_ppn, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Both ports request back to back: imem, dmem, imem, then a pending dmem is withdrawn.
    set_mem(64'h00111000_00000003, 64'h00222000_00000003, 64'h00333000_00000003, 0);
    ptbr_ppn = 32'h5;
    @(negedge clk);
    imem_ptw_req_valid = 1'b1; imem_ptw_req_bits_vpn = 20'h00400;
    dmem_ptw_req_valid = 1'b1; dmem_ptw_req_bits_vpn = 20'h00800;
    for (int k = 0; k < 3; k++) begin
      #1;
      guard = 0;
      while (!(imem_ptw_req_ready || dmem_ptw_req_ready) && guard < 20) begin
        @(negedge clk); #1; guard++;
      end
      chk($sformatf("arb%0d_grant", k), {imem_ptw_req_ready, dmem_ptw_req_ready},
          exp_dm[k] ? 2'b01 : 2'b10);
      chk($sformatf("arb%0d_prompt", k), 64'(guard), 0);
      t0 = cyc;
      @(negedge clk);
      if (k == 2) begin
        imem_ptw_req_valid = 1'b0;
        dmem_ptw_req_valid = 1'b0;
      end
      #1;
      guard = 0;
      wrong = 1'b0;
      while (!(imem_ptw_resp_valid || dmem_ptw_resp_valid) && guard < 30) begin
        if (imem_ptw_req_ready || dmem_ptw_req_ready) wrong = 1'b1;
        @(negedge clk); #1; guard++;
      end
      chk($sformatf("arb%0d_resp_port", k), {imem_ptw_resp_valid, dmem_ptw_resp_valid},
          exp_dm[k] ? 2'b01 : 2'b10);
      chk($sformatf("arb%0d_no_ready_in_walk", k), wrong, 0);
      chk($sformatf("arb%0d_ppn", k),
          exp_dm[k] ? dmem_ptw_resp_bits_ppn : imem_ptw_resp_bits_ppn, arb_ppn[k]);
      chk($sformatf("arb%0d_latency", k), 64'(cyc - t0), 3);
      chk($sformatf("arb%0d_addr", k), addr_arr[k], arb_addr[k]);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("arb_withdrawn_idle", {mem_req_valid, 64'(n_reads)}, 64'd3);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while waiting for the root PTE, then a stale response after release.
    set_mem(64'h00000020_00000001, 64'h0, 64'h0, 0);
    hold_resp = 1'b1;
    ptbr_ppn = 32'h10;
    @(negedge clk);
    imem_ptw_req_valid = 1'b1; imem_ptw_req_bits_vpn = 20'h00401;
    #1;
    guard = 0;
    while (!imem_ptw_req_ready && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    chk("rstw_grant", imem_ptw_req_ready, 1);
    @(negedge clk);
    imem_ptw_req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rstw_read_issued", 64'(n_reads), 1);
    reset_n = 1'b0;
    #1;
    chk("rstw_mem_req_drop", mem_req_valid, 0);
    chk("rstw_resp_quiet", {imem_ptw_resp_valid, dmem_ptw_resp_valid}, 0);
    chk("rstw_ppn_cleared", imem_ptw_resp_bits_ppn, 0);
    @(negedge clk);
    reset_n = 1'b1;
    hold_resp = 1'b0;
    wrong = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (imem_ptw_resp_valid || dmem_ptw_resp_valid || mem_req_valid) wrong = 1'b1;
    end
    chk("rstw_stale_delivered", 64'(rd_idx), 1);
    chk("rstw_stale_ignored", wrong, 0);
    run_vec(vecs[7], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time actual=expired required=finish");
    $fatal(1, "watchdog");
  end

endmodule
